// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   state_e    : arbiter FSM state (IDLE / ACCESS)
//   owner_e    : which pipeline stage owns the access in flight
//   mem_req_t  : request selected by the arbiter in the grant cycle
//   misaligned : flags a byte address that is not word aligned
package mips_mem_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         STARVE_W        = 3;   // starvation counter width
  localparam int         WAIT_W          = 3;   // wait-state counter width (0..7)

  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |(lsb & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the ACCESS phase.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i (grant of an aligned access)
//   load_val_i  : number of extra wait cycles
//   dec_i       : count down (asserted while in ACCESS)
//   tc_o        : terminal count, high when the counter reads zero
module mem_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = load_val_i;
    else if (dec_i && |cnt_q)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the fetch stage (read
// only) and the memory stage (load/store). One access at a time; the address
// and write data are held for WAIT_STATES+1 cycles, stores pulse the write
// enable once in the last of them, and completion is a one-cycle rvalid.
//   clk, rst_n                         : clock, async active-low reset
//   if_req/if_addr -> if_gnt           : fetch request / accept
//   if_rvalid/if_rdata/if_err          : fetch completion
//   dm_req/dm_we/dm_addr/dm_wdata      : data request
//   dm_gnt, dm_rvalid/dm_rdata/dm_err  : data accept / completion
//   mem_wr_en/mem_addr/mem_din/mem_dout: memory side
//   busy                               : access in flight
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  state_e              state_q;
  owner_e              own_q;
  logic                we_q;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_rvalid_q, dm_rvalid_q, if_err_q, dm_err_q;
  logic [31:0]         if_rdata_q, dm_rdata_q, mem_addr_q, mem_din_q;

  logic     idle, if_win, dm_win, any_gnt, req_misal, start, wait_tc;
  mem_req_t req_d;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign idle    = rst_n && (state_q == IDLE);
  assign if_win  = idle && if_req && (!dm_req || starve_q == STARVE_W'(STARVE_MAX));
  assign dm_win  = idle && dm_req && !if_win;
  assign any_gnt = if_win || dm_win;

  always_comb begin
    req_d.owner = OWN_DM;
    req_d.we    = dm_we;
    req_d.addr  = dm_addr;
    req_d.wdata = dm_wdata;
    if (if_win) begin
      req_d.owner = OWN_IF;
      req_d.we    = 1'b0;
      req_d.addr  = if_addr;
      req_d.wdata = '0;
    end
  end

  assign req_misal = misaligned(req_d.addr[1:0]);
  // Misaligned requests are answered directly from IDLE without touching memory.
  assign start     = any_gnt && !req_misal;

  // Fetch is only counted as starving while it is actually asking.
  always_comb begin
    starve_d = starve_q;
    if (if_win)                starve_d = '0;
    else if (dm_win && if_req) starve_d = starve_q + 1'b1;
    else if (idle && !if_req)  starve_d = '0;
  end

  mem_wait_counter #(.W(WAIT_W)) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start),
    .load_val_i (WAIT_W'(WAIT_STATES)),
    .dec_i      (state_q == ACCESS),
    .tc_o       (wait_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_IF;
      we_q        <= 1'b0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_gnt) begin
            if (req_misal) begin
              if (req_d.owner == OWN_IF) begin
                if_rvalid_q <= 1'b1;
                if_err_q    <= 1'b1;
                if_rdata_q  <= '0;
              end else begin
                dm_rvalid_q <= 1'b1;
                dm_err_q    <= 1'b1;
                dm_rdata_q  <= '0;
              end
            end else begin
              own_q      <= req_d.owner;
              we_q       <= req_d.we;
              mem_addr_q <= req_d.addr;
              mem_din_q  <= req_d.wdata;
              state_q    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (wait_tc) begin
            state_q <= IDLE;
            if (own_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_dout;
            end else begin
              dm_rvalid_q <= 1'b1;
              dm_rdata_q  <= we_q ? 32'h0 : mem_dout;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_win;
  assign dm_gnt    = dm_win;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign busy      = (state_q == ACCESS);
  // Decoded from registered state only, so a single clean pulse per store.
  assign mem_wr_en = (state_q == ACCESS) && wait_tc && we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int NI  = 3;          // instances: 0 -> WS=1, 1 -> WS=0, 2 -> WS=3
  localparam int WS0 = 1;
  localparam int WS1 = 0;
  localparam int WS2 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [NI];
  logic        if_req [NI], dm_req [NI], dm_we [NI];
  logic [31:0] if_addr [NI], dm_addr [NI], dm_wdata [NI];
  logic        if_gnt [NI], if_rvalid [NI], if_err [NI];
  logic        dm_gnt [NI], dm_rvalid [NI], dm_err [NI], mem_wr_en [NI], busy [NI];
  logic [31:0] if_rdata [NI], dm_rdata [NI], mem_addr [NI], mem_din [NI], mem_dout [NI];
  logic [31:0] mem [NI][64];

  for (genvar g = 0; g < NI; g++) begin : gi
    mem_port_arbiter #(
      .WAIT_STATES((g == 0) ? WS0 : (g == 1) ? WS1 : WS2),
      .STARVE_MAX (SMAX)
    ) dut (
      .clk(clk), .rst_n(rst_n[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]), .if_err(if_err[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]), .dm_err(dm_err[g]),
      .mem_wr_en(mem_wr_en[g]), .mem_addr(mem_addr[g]), .mem_din(mem_din[g]),
      .mem_dout(mem_dout[g]), .busy(busy[g])
    );
    assign mem_dout[g] = mem[g][mem_addr[g][7:2]];
  end

  function automatic logic [31:0] init_word(input int k, input int i);
    return {16'hC0DE, 8'(k), 8'(i)};
  endfunction

  // Memory behind each arbiter: preloaded on the first edge, written on mem_wr_en.
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 64; i++)
        if (!mem_ready) mem[k][i] <= init_word(k, i);
    mem_ready = 1'b1;
    for (int k = 0; k < NI; k++)
      if (mem_wr_en[k]) mem[k][mem_addr[k][7:2]] <= mem_din[k];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        err;
    logic [31:0] data;
    logic        we;
    int          widx;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q_if [NI][$];
  exp_t        q_dm [NI][$];
  logic [31:0] model [NI][64];
  bit          gnt_log [$];   // instance 0 grant order, 1 = data port
  int          n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n[k]) begin
        q_if[k].delete();
        q_dm[k].delete();
        continue;
      end
      if (if_rvalid[k]) begin
        if (q_if[k].size() == 0) chk($sformatf("inst%0d if_rvalid unexpected", k), 64'd1, 64'd0);
        else begin
          e = q_if[k].pop_front();
          chk($sformatf("inst%0d if_rsp", k), {31'b0, if_err[k], if_rdata[k]}, {31'b0, e.err, e.data});
        end
      end
      if (dm_rvalid[k]) begin
        if (q_dm[k].size() == 0) chk($sformatf("inst%0d dm_rvalid unexpected", k), 64'd1, 64'd0);
        else begin
          e = q_dm[k].pop_front();
          chk($sformatf("inst%0d dm_rsp", k), {31'b0, dm_err[k], dm_rdata[k]}, {31'b0, e.err, e.data});
          if (e.we && !e.err) model[k][e.widx] = e.wdata;
        end
      end
      if (if_gnt[k] && dm_gnt[k]) chk($sformatf("inst%0d double gnt", k), 64'd1, 64'd0);
      if ((if_gnt[k] || dm_gnt[k]) && busy[k]) chk($sformatf("inst%0d gnt while busy", k), 64'd1, 64'd0);
      if (if_gnt[k]) begin
        e.err  = |if_addr[k][1:0];
        e.data = e.err ? 32'h0 : model[k][if_addr[k][7:2]];
        e.we   = 1'b0; e.widx = 0; e.wdata = '0;
        q_if[k].push_back(e);
        if (k == 0) gnt_log.push_back(1'b0);
      end
      if (dm_gnt[k]) begin
        e.err   = |dm_addr[k][1:0];
        e.data  = (e.err || dm_we[k]) ? 32'h0 : model[k][dm_addr[k][7:2]];
        e.we    = dm_we[k];
        e.widx  = int'(dm_addr[k][7:2]);
        e.wdata = dm_wdata[k];
        q_dm[k].push_back(e);
        if (k == 0) gnt_log.push_back(1'b1);
      end
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic wait_gnt(input int k, input bit dm, output int t, output bit ok);
    ok = 1'b0; t = cyc;
    for (int n = 0; n < 50; n++) begin
      if (dm ? dm_gnt[k] : if_gnt[k]) begin ok = 1'b1; t = cyc; return; end
      adv(); smp();
    end
  endtask

  // ---------------- table vectors (instance 0, WAIT_STATES=1) ----------------
  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;    // grant cycle to rvalid cycle
    int          nwr;    // expected mem_wr_en pulses
  } vec_t;

  vec_t tbl [10];

  task automatic run_vec(input int idx, input vec_t v);
    int t0, nwr, wr_off;
    bit ok;
    logic [31:0] ma0, rd;
    logic er;
    adv();
    if (v.dm) begin dm_req[0] = 1'b1; dm_we[0] = v.we; dm_addr[0] = v.addr; dm_wdata[0] = v.wdata; end
    else begin if_req[0] = 1'b1; if_addr[0] = v.addr; end
    smp();
    wait_gnt(0, v.dm, t0, ok);
    chk($sformatf("vec%0d gnt", idx), 64'(ok), 64'd1);
    ma0 = mem_addr[0];
    adv(); if_req[0] = 1'b0; dm_req[0] = 1'b0; smp();
    nwr = 0; wr_off = -1; ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (mem_wr_en[0]) begin nwr++; wr_off = cyc - t0; end
      if (v.dm ? dm_rvalid[0] : if_rvalid[0]) begin ok = 1'b1; break; end
      adv(); smp();
    end
    rd = v.dm ? dm_rdata[0] : if_rdata[0];
    er = v.dm ? dm_err[0] : if_err[0];
    chk($sformatf("vec%0d rvalid seen", idx), 64'(ok), 64'd1);
    chk($sformatf("vec%0d latency", idx), 64'(cyc - t0), 64'(v.lat));
    chk($sformatf("vec%0d rsp", idx), {31'b0, er, rd}, {31'b0, v.err, v.rdata});
    chk($sformatf("vec%0d wr pulses", idx), 64'(nwr), 64'(v.nwr));
    if (v.nwr != 0) chk($sformatf("vec%0d wr cycle", idx), 64'(wr_off), 64'(WS0 + 1));
    chk($sformatf("vec%0d mem_addr", idx), 64'(mem_addr[0]), 64'(v.err ? ma0 : v.addr));
  endtask

  initial begin
    int t0, gc[$], rc[$], nwr, nrv;
    bit ok;

    tbl[0] = '{1'b0, 1'b0, 32'h14, 32'h0,         1'b0, 32'hC0DE0005, 3, 0};
    tbl[1] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF,  1'b0, 32'h0,        3, 1};
    tbl[2] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEADBEEF, 3, 0};
    tbl[3] = '{1'b1, 1'b0, 32'h06, 32'h0,         1'b1, 32'h0,        1, 0};
    tbl[4] = '{1'b1, 1'b1, 32'h13, 32'h11111111,  1'b1, 32'h0,        1, 0};
    tbl[5] = '{1'b0, 1'b0, 32'h02, 32'h0,         1'b1, 32'h0,        1, 0};
    tbl[6] = '{1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEADBEEF, 3, 0};
    tbl[7] = '{1'b1, 1'b1, 32'h20, 32'h12345678,  1'b0, 32'h0,        3, 1};
    tbl[8] = '{1'b0, 1'b0, 32'h20, 32'h0,         1'b0, 32'h12345678, 3, 0};
    tbl[9] = '{1'b1, 1'b0, 32'h3C, 32'h0,         1'b0, 32'hC0DE000F, 3, 0};

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 64; i++) model[k][i] = init_word(k, i);
      rst_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
    end

    // Reset with random inputs: every output must read zero.
    for (int c = 0; c < 4; c++) begin
      adv();
      for (int k = 0; k < NI; k++) begin
        if_req[k] = 1'($urandom); if_addr[k] = $urandom;
        dm_req[k] = 1'($urandom); dm_we[k] = 1'($urandom);
        dm_addr[k] = $urandom; dm_wdata[k] = $urandom;
      end
      smp();
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("inst%0d reset flags", k),
            64'({if_gnt[k], if_rvalid[k], if_err[k], dm_gnt[k], dm_rvalid[k], dm_err[k], mem_wr_en[k], busy[k]}), 64'd0);
        chk($sformatf("inst%0d reset rdata", k), {if_rdata[k], dm_rdata[k]}, 64'd0);
        chk($sformatf("inst%0d reset mem", k), {mem_addr[k], mem_din[k]}, 64'd0);
      end
    end

    // Release reset with a fetch of 0x0 already pending.
    adv();
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b1; if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
    end
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    smp();
    chk("first fetch gnt", 64'(if_gnt[0]), 64'd1);
    t0 = cyc;
    adv(); if_req[0] = 1'b0; smp();
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (if_rvalid[0]) begin ok = 1'b1; break; end
      adv(); smp();
    end
    chk("first fetch rvalid", 64'(ok), 64'd1);
    chk("first fetch latency", 64'(cyc - t0), 64'(WS0 + 2));
    chk("first fetch rdata", 64'(if_rdata[0]), 64'(init_word(0, 0)));

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Contention: both ports request continuously.
    adv();
    gnt_log.delete();
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h4;
    smp();
    for (int n = 0; n < 100 && gnt_log.size() < 10; n++) begin adv(); smp(); end
    adv(); if_req[0] = 1'b0; dm_req[0] = 1'b0; smp();
    for (int n = 0; n < 8; n++) begin adv(); smp(); end
    chk("contention grant count", 64'(gnt_log.size()), 64'd10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++)
      chk($sformatf("contention grant %0d is dm", i), 64'(gnt_log[i]), 64'((i == 4 || i == 9) ? 0 : 1));

    // Back-to-back loads on the zero-wait-state instance.
    adv(); dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h8; smp();
    for (int n = 0; n < 40; n++) begin
      if (dm_rvalid[1]) rc.push_back(cyc);
      if (dm_gnt[1])    gc.push_back(cyc);
      if (rc.size() >= 3) break;
      adv();
      if (gc.size() >= 3) dm_req[1] = 1'b0;
      smp();
    end
    chk("b2b grant count", 64'(gc.size()), 64'd3);
    chk("b2b rvalid count", 64'(rc.size()), 64'd3);
    if (gc.size() == 3 && rc.size() == 3) begin
      chk("b2b first latency", 64'(rc[0] - gc[0]), 64'd2);
      chk("b2b spacing 0-1", 64'(rc[1] - rc[0]), 64'd2);
      chk("b2b spacing 1-2", 64'(rc[2] - rc[1]), 64'd2);
      chk("b2b gnt in rvalid cycle 1", 64'(gc[1]), 64'(rc[0]));
      chk("b2b gnt in rvalid cycle 2", 64'(gc[2]), 64'(rc[1]));
    end

    // Reset in the first ACCESS cycle of a store (WAIT_STATES=3) aborts it.
    adv();
    dm_req[2] = 1'b1; dm_we[2] = 1'b1; dm_addr[2] = 32'h30; dm_wdata[2] = 32'hFEEDFACE;
    smp();
    wait_gnt(2, 1'b1, t0, ok);
    chk("abort store gnt", 64'(ok), 64'd1);
    adv(); dm_req[2] = 1'b0; dm_we[2] = 1'b0; smp();
    chk("abort store busy in access", 64'(busy[2]), 64'd1);
    rst_n[2] = 1'b0;
    nwr = 0; nrv = 0;
    for (int n = 0; n < 3; n++) begin
      adv(); smp();
      if (mem_wr_en[2]) nwr++;
      if (dm_rvalid[2]) nrv++;
    end
    chk("abort busy during reset", 64'(busy[2]), 64'd0);
    adv(); rst_n[2] = 1'b1; smp();
    for (int n = 0; n < 10; n++) begin
      if (mem_wr_en[2]) nwr++;
      if (dm_rvalid[2]) nrv++;
      adv(); smp();
    end
    chk("abort no mem_wr_en", 64'(nwr), 64'd0);
    chk("abort no dm_rvalid", 64'(nrv), 64'd0);
    chk("abort memory unchanged", 64'(mem[2][12]), 64'(init_word(2, 12)));

    for (int k = 0; k < NI; k++) begin
      chk($sformatf("inst%0d if responses outstanding", k), 64'(q_if[k].size()), 64'd0);
      chk($sformatf("inst%0d dm responses outstanding", k), 64'(q_dm[k].size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified instruction/data memory between the pipeline's fetch stage (read-only) and memory stage (load/store). Accepts one request at a time, holds the memory's address and write-data stable for a programmable number of wait states, and pulses a write enable exactly once per store. It returns read data with a completion pulse. It sits between the IF/MEM pipeline stages and the memory, and replaces their direct wiring to it.

## Interface
- WAIT_STATES, 1, extra cycles the memory address is held before completion (0..7)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted (combinational, one cycle)
- if_rvalid  out  1  fetch completion pulse
- if_rdata  out  32  fetched instruction, valid with if_rvalid
- if_err  out  1  misaligned fetch, valid with if_rvalid
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data request accepted (combinational, one cycle)
- dm_rvalid  out  1  data completion pulse (loads and stores)
- dm_rdata  out  32  load data, valid with dm_rvalid; 0 for stores
- dm_err  out  1  misaligned data access, valid with dm_rvalid
- mem_wr_en  out  1  memory write enable
- mem_addr  out  32  memory address (registered)
- mem_din  out  32  memory write data (registered)
- mem_dout  in  32  memory read data (combinational from mem_addr)
- busy  out  1  access in flight

## Operation
- States: IDLE, ACCESS. ACCESS lasts WAIT_STATES+1 cycles, counted by wait_cnt.
- IDLE with any request: grant exactly one requester. The granted request's addr/we/wdata/owner are registered and the FSM enters ACCESS.
- Priority: dm wins by default. IF wins when starve_cnt == STARVE_MAX.
- starve_cnt (3 bits) increments when dm is granted while if_req=1. It clears when IF is granted, or in IDLE when if_req=0.
- Misaligned request (addr[1:0] != 0): gnt still pulses, but no memory access occurs (no mem_wr_en, mem_addr unchanged).
  - Next cycle: rvalid=1, err=1, rdata=0. FSM stays in IDLE.
  - starve_cnt updates as for a normal grant.
- ACCESS: mem_addr/mem_din hold the registered values.
  - Store: mem_wr_en=1 only in the final ACCESS cycle.
  - Load: mem_dout is captured into the owner's rdata at the end of the final ACCESS cycle.
- Completion: the owner's rvalid is registered and high for one cycle, the first IDLE cycle after ACCESS. err=0.
- gnt is never asserted outside IDLE. Requests arriving during ACCESS wait.
- No request is ever dropped or duplicated. Each gnt produces exactly one rvalid.
- Reset values: state IDLE, all gnt/rvalid/err/mem_wr_en/busy = 0, all rdata = 0, mem_addr = 0, mem_din = 0, starve_cnt = 0, wait_cnt = 0.
- Reset asserted mid-ACCESS aborts the access: no rvalid and no further mem_wr_en. The requester reissues after reset.

## Timing
- Cycle T: IDLE, req=1 → gnt=1 combinationally.
- Cycles T+1 .. T+1+WAIT_STATES: ACCESS, busy=1.
- Cycle T+WAIT_STATES+2: rvalid=1. The FSM is back in IDLE and may grant a new request in this same cycle (back-to-back).
- Throughput: one aligned access per WAIT_STATES+2 cycles.
- Misaligned access: rvalid/err at T+1. The next grant is possible at T+1.
- mem_wr_en is decoded from state/wait_cnt/we; it is glitch-free only via registered inputs.
- Simultaneous completion and new request in the same cycle is legal.

## Structure
- Package mips_mem_pkg:
  - state enum {IDLE, ACCESS}
  - owner enum {OWN_IF, OWN_DM}
  - WORD_ALIGN_MASK = 2'b11
  - starvation counter width
- One natural sub-module: mem_wait_counter, a loadable down-counter with a terminal-count flag. It is loaded with WAIT_STATES on grant and decrements in ACCESS.
- Arbitration and starvation logic stay in the top module.

## Test plan
- Reset: drive rst_n=0 with random inputs → all outputs 0. Release, if_req=1, if_addr=0x0 → if_gnt at first edge; if_rvalid with if_rdata = mem word at 0x0 after WAIT_STATES+1 more cycles.
- Store then load: dm store 0xDEADBEEF to 0x10, then load 0x10 → exactly one mem_wr_en pulse, in the final ACCESS cycle. Load returns dm_rdata=0xDEADBEEF.
- Contention: if_req and dm_req held continuously, STARVE_MAX=4 → grant order dm,dm,dm,dm,if,dm,dm,dm,dm,if.
- Misaligned: dm load at 0x6 → dm_gnt, then dm_rvalid=1 and dm_err=1 next cycle. No mem_wr_en; mem_addr unchanged.
- Back-to-back: WAIT_STATES=0, dm_req held across 3 loads → completions spaced exactly 2 cycles apart, with a new gnt in each rvalid cycle.
- Mid-access reset: assert rst_n=0 in the first ACCESS cycle of a store with WAIT_STATES=3 → no mem_wr_en, no dm_rvalid, memory word unchanged.
